// File: rtl/alu4_prog_sequencer.sv
// ---------------------------------------------------------------------------
// alu4_prog_sequencer
// Drives an external combinational 4-bit ALU from a small loadable program.
// Each program byte is {opcode[7:4], operand[3:0]}. The ALU A input is the
// internal accumulator and B is the operand; the result and zero flag are
// captured back into the accumulator and zero_flag.
//
// Ports
//   i_clk, i_rst_n        clock (rising edge), async active-low reset
//   i_load_valid/_data    program byte strobe and byte
//   o_load_ready          byte will be accepted this cycle
//   i_prog_clr            empty the program (IDLE only)
//   i_start               begin execution (IDLE only, program non-empty)
//   o_alu_opcode/_a/_b    to ALU; live while o_exec_valid is high
//   i_alu_result/_zero    from ALU
//   o_acc, o_zero_flag    accumulator and last captured zero flag
//   o_pc                  index of the current instruction
//   o_busy, o_done        not IDLE / one-cycle completion pulse
//
// state   | meaning
// S_IDLE  | accept loads, clear and start
// S_FETCH | read prog[pc] into the ALU operand registers
// S_EXEC  | ALU inputs live; capture result at the edge
// S_DONE  | one-cycle done pulse, then back to IDLE
// ---------------------------------------------------------------------------
module alu4_prog_sequencer #(
    parameter int         PROG_DEPTH = 8,
    parameter int         PC_W       = 3,
    parameter logic [3:0] ACC_INIT   = 4'h0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_load_valid,
    input  logic [7:0]      i_load_data,
    output logic            o_load_ready,
    input  logic            i_prog_clr,
    input  logic            i_start,
    output logic [3:0]      o_alu_opcode,
    output logic [3:0]      o_alu_a,
    output logic [3:0]      o_alu_b,
    input  logic [3:0]      i_alu_result,
    input  logic            i_alu_zero,
    output logic            o_exec_valid,
    output logic [3:0]      o_acc,
    output logic            o_zero_flag,
    output logic [PC_W-1:0] o_pc,
    output logic            o_busy,
    output logic            o_done
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;

    localparam logic [PC_W:0]   C_DEPTH = (PC_W+1)'(PROG_DEPTH);
    localparam logic [PC_W:0]   C_ONE   = (PC_W+1)'(1);
    localparam logic [PC_W-1:0] C_PC1   = PC_W'(1);

    state_t          r_state;
    logic [7:0]      r_prog [PROG_DEPTH];
    logic [PC_W:0]   r_count;
    logic [PC_W-1:0] r_wr_ptr;
    logic [PC_W-1:0] r_pc;

    logic w_idle;
    logic w_load_acc;
    logic w_last;

    assign w_idle       = (r_state == S_IDLE);
    assign o_load_ready = w_idle && (r_count < C_DEPTH);
    // Clear wins over a simultaneous load.
    assign w_load_acc   = o_load_ready && i_load_valid && !i_prog_clr;
    assign w_last       = ({1'b0, r_pc} == (r_count - C_ONE));
    assign o_pc         = r_pc;

    // Program storage is deliberately not reset; count=0 hides stale bytes.
    always_ff @(posedge i_clk) begin
        if (w_load_acc) begin
            r_prog[r_wr_ptr] <= i_load_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_pc         <= '0;
            o_acc        <= ACC_INIT;
            o_zero_flag  <= 1'b0;
            o_alu_opcode <= 4'h0;
            o_alu_a      <= 4'h0;
            o_alu_b      <= 4'h0;
            o_exec_valid <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_prog_clr) begin
                        r_count  <= '0;
                        r_wr_ptr <= '0;
                    end else if (w_load_acc) begin
                        r_count  <= r_count + C_ONE;
                        r_wr_ptr <= r_wr_ptr + C_PC1;
                    end else if (i_start && (r_count != '0)) begin
                        o_acc       <= ACC_INIT;
                        o_zero_flag <= 1'b0;
                        r_pc        <= '0;
                        o_busy      <= 1'b1;
                        r_state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Fetch and operand register are merged so each
                    // instruction takes exactly two cycles.
                    o_alu_opcode <= r_prog[r_pc][7:4];
                    o_alu_b      <= r_prog[r_pc][3:0];
                    o_alu_a      <= o_acc;
                    o_exec_valid <= 1'b1;
                    r_state      <= S_EXEC;
                end
                S_EXEC: begin
                    o_acc        <= i_alu_result;
                    o_zero_flag  <= i_alu_zero;
                    o_exec_valid <= 1'b0;
                    if (w_last) begin
                        o_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_pc    <= r_pc + C_PC1;
                        r_state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
